// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, defaults and index helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // Successor of idx in a ring of n slots.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set search starting at a pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int unsigned cand;
    idx   = '0;
    found = 1'b0;
    cand  = 32'd0;
    for (int i = 0; i < N; i++) begin
      cand = (32'(start) + 32'(i)) % 32'(N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO memory write port
// plus a saturating write-error counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          write_error,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          err_cnt
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state, state_nxt;
  logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [OW-1:0]   pick_idx;
  logic            pick_found;
  logic [OW-1:0]   owner_succ;
  logic [DATA_WIDTH-1:0] slot [NUM_REQ];

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_rr_pick (
    .req   (req),
    .start (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owner_succ = OW'(next_idx(32'(owner), 32'(NUM_REQ)));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // full is checked before any grant, so the full-on-last-word case lands in HOLD.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    grant         = '0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nxt     = pick_idx;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          rr_ptr_nxt = owner_succ;
          state_nxt  = IDLE;
        end else if (full) begin
          state_nxt = HOLD;
        end else begin
          grant[owner]  = 1'b1;
          burst_cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt + 1'b1 == BW'(MAX_BURST)) begin
            rr_ptr_nxt = owner_succ;
            state_nxt  = IDLE;
          end
        end
      end
      HOLD: begin
        if (!req[owner]) begin
          rr_ptr_nxt = owner_succ;
          state_nxt  = IDLE;
        end else if (!full) begin
          state_nxt = BURST;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (w_rst) begin
      grant = '0;
    end
  end

  assign w_en    = |grant;
  assign data_in = w_en ? slot[owner] : '0;
  assign busy    = !w_rst && (state != IDLE);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      err_cnt <= '0;
    end else if (write_error && (err_cnt != {CNT_WIDTH{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic        write_error;

  logic [3:0]  grant;
  logic        w_en;
  logic [7:0]  data_in;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] err_cnt;

  logic [3:0]  grant_c4;
  logic        w_en_c4;
  logic [7:0]  data_in_c4;
  logic [1:0]  owner_c4;
  logic        busy_c4;
  logic [3:0]  err_cnt_c4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .w_en        (w_en),
    .data_in     (data_in),
    .full        (full),
    .write_error (write_error),
    .owner       (owner),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  fifo_wr_arbiter #(.CNT_WIDTH(4)) dut_c4 (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant_c4),
    .w_en        (w_en_c4),
    .data_in     (data_in_c4),
    .full        (full),
    .write_error (write_error),
    .owner       (owner_c4),
    .busy        (busy_c4),
    .err_cnt     (err_cnt_c4)
  );

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    w_rst = 1'b1; req = 4'b1111; req_data = 32'h0302_0100; full = 1'b0; write_error = 1'b1;
    tick;
    settle;
    total_cnt++;
    if ({grant, w_en, busy, data_in} !== 14'h0)
      $display("FAIL reset_outputs: got %h expected %h", {grant, w_en, busy, data_in}, 14'h0);
    else pass_cnt++;
    total_cnt++;
    if ({err_cnt, err_cnt_c4} !== 20'h0)
      $display("FAIL reset_err_cnt: got %h expected %h", {err_cnt, err_cnt_c4}, 20'h0);
    else pass_cnt++;
    w_rst = 1'b0; req = 4'b0000; write_error = 1'b0;
    tick;
  endtask

  task automatic test_single_stream;
    logic [7:0] exp_d;
    req_data = 32'h0000_0010; req = 4'b0001; full = 1'b0;
    for (int b = 0; b < 2; b++) begin
      settle;
      total_cnt++;
      if ({grant, w_en, busy} !== 6'b0)
        $display("FAIL stream_idle: got %b expected %b", {grant, w_en, busy}, 6'b0);
      else pass_cnt++;
      tick;
      for (int k = 0; k < 4; k++) begin
        exp_d = 8'h10 + 8'(4*b + k);
        settle;
        total_cnt++;
        if ({grant, w_en, busy, data_in} !== {4'b0001, 2'b11, exp_d})
          $display("FAIL stream_grant: got %h expected %h", {grant, w_en, busy, data_in}, {4'b0001, 2'b11, exp_d});
        else pass_cnt++;
        tick;
        req_data[7:0] = req_data[7:0] + 8'd1;
      end
    end
    req = 4'b0000;
    tick;
  endtask

  task automatic test_all_active;
    logic [1:0] exp_o;
    w_rst = 1'b1; tick; w_rst = 1'b0;
    req = 4'b1111; req_data = 32'hA3A2_A1A0; full = 1'b0;
    for (int b = 0; b < 5; b++) begin
      exp_o = 2'(b % 4);
      settle;
      total_cnt++;
      if ({grant, busy} !== 5'b0)
        $display("FAIL all_idle: got %b expected %b", {grant, busy}, 5'b0);
      else pass_cnt++;
      tick;
      for (int k = 0; k < 4; k++) begin
        settle;
        total_cnt++;
        if ({grant, w_en, busy, owner, data_in} !== {4'b0001 << exp_o, 2'b11, exp_o, 8'hA0 + 8'(exp_o)})
          $display("FAIL all_grant: got %h expected %h", {grant, w_en, busy, owner, data_in},
                   {4'b0001 << exp_o, 2'b11, exp_o, 8'hA0 + 8'(exp_o)});
        else pass_cnt++;
        tick;
      end
    end
    req = 4'b0000;
    tick;
  endtask

  task automatic test_full_stall;
    req = 4'b0010; req_data[15:8] = 8'h50; full = 1'b0;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b0)
      $display("FAIL stall_idle: got %b expected %b", {grant, w_en, busy}, 6'b0);
    else pass_cnt++;
    tick;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        full = 1'b1;
        for (int s = 0; s < 5; s++) begin
          settle;
          total_cnt++;
          if ({grant, w_en, busy} !== 6'b000001)
            $display("FAIL stall_hold: got %b expected %b", {grant, w_en, busy}, 6'b000001);
          else pass_cnt++;
          tick;
        end
        full = 1'b0;
        settle;
        total_cnt++;
        if ({grant, w_en, busy} !== 6'b000001)
          $display("FAIL stall_resume: got %b expected %b", {grant, w_en, busy}, 6'b000001);
        else pass_cnt++;
        tick;
      end
      settle;
      total_cnt++;
      if ({grant, w_en, busy, data_in} !== {4'b0010, 2'b11, 8'h50 + 8'(k)})
        $display("FAIL stall_grant: got %h expected %h", {grant, w_en, busy, data_in}, {4'b0010, 2'b11, 8'h50 + 8'(k)});
      else pass_cnt++;
      tick;
      req_data[15:8] = req_data[15:8] + 8'd1;
    end
    req = 4'b0110; req_data[23:16] = 8'h70;
    settle;
    total_cnt++;
    if ({grant, busy} !== 5'b0)
      $display("FAIL stall_rot_idle: got %b expected %b", {grant, busy}, 5'b0);
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, owner, data_in} !== {4'b0100, 2'd2, 8'h70})
      $display("FAIL stall_rotate: got %h expected %h", {grant, owner, data_in}, {4'b0100, 2'd2, 8'h70});
    else pass_cnt++;
    tick;
  endtask

  task automatic test_hold_withdraw;
    req = 4'b1000; req_data[31:24] = 8'h90;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b000001)
      $display("FAIL wd_burst_drop: got %b expected %b", {grant, w_en, busy}, 6'b000001);
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, busy} !== 5'b0)
      $display("FAIL wd_idle: got %b expected %b", {grant, busy}, 5'b0);
    else pass_cnt++;
    tick;
    full = 1'b1;
    settle;
    total_cnt++;
    if ({grant, busy, owner} !== {4'b0, 1'b1, 2'd3})
      $display("FAIL wd_burst3_full: got %h expected %h", {grant, busy, owner}, {4'b0, 1'b1, 2'd3});
    else pass_cnt++;
    tick;
    req = 4'b1001;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b000001)
      $display("FAIL wd_hold: got %b expected %b", {grant, w_en, busy}, 6'b000001);
    else pass_cnt++;
    tick;
    req = 4'b0001;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b000001)
      $display("FAIL wd_hold_drop: got %b expected %b", {grant, w_en, busy}, 6'b000001);
    else pass_cnt++;
    tick;
    full = 1'b0; req = 4'b1111; req_data[7:0] = 8'h20;
    settle;
    total_cnt++;
    if ({grant, busy} !== 5'b0)
      $display("FAIL wd_back_idle: got %b expected %b", {grant, busy}, 5'b0);
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, owner, data_in} !== {4'b0001, 2'd0, 8'h20})
      $display("FAIL wd_rr_ptr0: got %h expected %h", {grant, owner, data_in}, {4'b0001, 2'd0, 8'h20});
    else pass_cnt++;
    tick;
    req_data[7:0] = 8'h21;
  endtask

  task automatic test_full_on_last;
    for (int k = 0; k < 2; k++) begin
      settle;
      total_cnt++;
      if ({grant, data_in} !== {4'b0001, 8'h21 + 8'(k)})
        $display("FAIL last_pre: got %h expected %h", {grant, data_in}, {4'b0001, 8'h21 + 8'(k)});
      else pass_cnt++;
      tick;
      req_data[7:0] = req_data[7:0] + 8'd1;
    end
    full = 1'b1;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b000001)
      $display("FAIL last_full: got %b expected %b", {grant, w_en, busy}, 6'b000001);
    else pass_cnt++;
    tick;
    full = 1'b0;
    settle;
    total_cnt++;
    if ({grant, w_en, busy} !== 6'b000001)
      $display("FAIL last_hold: got %b expected %b", {grant, w_en, busy}, 6'b000001);
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, owner, data_in} !== {4'b0001, 2'd0, 8'h23})
      $display("FAIL last_grant: got %h expected %h", {grant, owner, data_in}, {4'b0001, 2'd0, 8'h23});
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, busy} !== 5'b0)
      $display("FAIL last_rotate_idle: got %b expected %b", {grant, busy}, 5'b0);
    else pass_cnt++;
    req = 4'b0000;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    w_rst = 1'b1; tick; w_rst = 1'b0;
    req = 4'b0100; req_data = 32'h0030_0040;
    tick;
    write_error = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle;
      total_cnt++;
      if ({grant, data_in} !== {4'b0100, 8'h30 + 8'(k)})
        $display("FAIL mid_grant: got %h expected %h", {grant, data_in}, {4'b0100, 8'h30 + 8'(k)});
      else pass_cnt++;
      tick;
      req_data[23:16] = req_data[23:16] + 8'd1;
    end
    write_error = 1'b0;
    w_rst = 1'b1; req = 4'b0101;
    settle;
    total_cnt++;
    if ({grant, w_en, busy, data_in, err_cnt} !== {14'h0, 16'd2})
      $display("FAIL mid_in_reset: got %h expected %h", {grant, w_en, busy, data_in, err_cnt}, {14'h0, 16'd2});
    else pass_cnt++;
    tick;
    w_rst = 1'b0;
    settle;
    total_cnt++;
    if ({grant, busy, err_cnt} !== {5'b0, 16'd0})
      $display("FAIL mid_after_reset: got %h expected %h", {grant, busy, err_cnt}, {5'b0, 16'd0});
    else pass_cnt++;
    tick;
    settle;
    total_cnt++;
    if ({grant, owner, data_in} !== {4'b0001, 2'd0, 8'h40})
      $display("FAIL mid_restart: got %h expected %h", {grant, owner, data_in}, {4'b0001, 2'd0, 8'h40});
    else pass_cnt++;
    req = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_err_cnt;
    w_rst = 1'b1; tick; w_rst = 1'b0;
    write_error = 1'b1;
    repeat (3) tick;
    write_error = 1'b0;
    settle;
    total_cnt++;
    if ({err_cnt, err_cnt_c4} !== {16'd3, 4'd3})
      $display("FAIL err_three: got %h expected %h", {err_cnt, err_cnt_c4}, {16'd3, 4'd3});
    else pass_cnt++;
    tick;
    write_error = 1'b1;
    repeat (17) tick;
    write_error = 1'b0;
    settle;
    total_cnt++;
    if ({err_cnt, err_cnt_c4} !== {16'd20, 4'd15})
      $display("FAIL err_saturate: got %h expected %h", {err_cnt, err_cnt_c4}, {16'd20, 4'd15});
    else pass_cnt++;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_stream;
    test_all_active;
    test_full_stall;
    test_hold_withdraw;
    test_full_on_last;
    test_reset_mid_burst;
    test_err_cnt;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
